// File: rtl/shift_ram_ctrl_if.sv
// Bus bundle between the delay-line controller, its sample source/sink and the
// external dual-port RAM.
interface shift_ram_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  enable;
    logic                  clear;
    logic [ADDR_WIDTH:0]   cfg_len;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            state;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  enable, clear, cfg_len, in_valid, in_data, ram_rdata,
        output out_valid, out_data, state,
               ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
    );

    modport master (
        output enable, clear, cfg_len, in_valid, in_data, ram_rdata,
        input  out_valid, out_data, state,
               ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr
    );
endinterface

// File: rtl/shift_ram_ctrl.sv
// Programmable sample delay line built on an external READ_FIRST RAM: each
// accepted sample reads the slot it is about to overwrite, len_q samples old.
module shift_ram_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_ram_ctrl_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_FILL = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] ZERO_L  = '0;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_fill_cnt;
    logic [ADDR_WIDTH:0]   r_len;
    logic                  r_out_valid;

    logic                  w_flush;
    logic                  w_accept;
    logic                  w_last_ptr;
    logic                  w_last_fill;
    logic [ADDR_WIDTH:0]   w_len_m1;
    logic [ADDR_WIDTH:0]   w_cfg_len_eff;

    // clear and enable=0 both flush; either one also blocks the RAM access
    assign w_flush  = bus.clear || !bus.enable;
    assign w_accept = (r_state != S_IDLE) && !w_flush && bus.in_valid;

    // len_q is never 0, so len_q-1 always fits in ADDR_WIDTH bits
    assign w_len_m1    = r_len - ONE_L;
    assign w_last_ptr  = (r_ptr == w_len_m1[ADDR_WIDTH-1:0]);
    assign w_last_fill = (r_fill_cnt == w_len_m1[ADDR_WIDTH-1:0]);

    assign w_cfg_len_eff = ((bus.cfg_len == ZERO_L) || (bus.cfg_len > DEPTH_L))
                         ? DEPTH_L : bus.cfg_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_FILL;
                S_FILL:  if (w_accept && w_last_fill) w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.state     = r_state;
        bus.ram_we    = w_accept;
        bus.ram_re    = w_accept;
        bus.ram_waddr = r_ptr;
        bus.ram_raddr = r_ptr;
        bus.ram_wdata = bus.in_data;
        bus.out_valid = r_out_valid;
        bus.out_data  = bus.ram_rdata;
    end

    // ptr and fill_cnt only move on accepted samples, so in_valid gaps are harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_fill_cnt  <= '0;
            r_len       <= DEPTH_L;
            r_out_valid <= 1'b0;
        end else if (w_flush) begin
            r_ptr       <= '0;
            r_fill_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept && (r_state == S_RUN);
            if (r_state == S_IDLE) begin
                r_len <= w_cfg_len_eff;
            end
            if (w_accept) begin
                r_ptr <= w_last_ptr ? '0 : r_ptr + 1'b1;
            end
            if (w_accept && (r_state == S_FILL)) begin
                r_fill_cnt <= w_last_fill ? '0 : r_fill_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shift_ram_ctrl.sv
// Directed bench for shift_ram_ctrl with a READ_FIRST 1-cycle-latency RAM model.
module tb_shift_ram_ctrl;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    shift_ram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();

    shift_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [0:1023];

    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_deep(input int cfg);
        bus.cfg_len = 11'(cfg);
        bus.enable  = 1'b1;
        tick();
        chk("deep_fill_entry", 32'(bus.state), 1);
        for (int i = 1; i <= 1030; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i);
            #1;
            if (i == 1024) chk("deep_ptr_top", 32'(bus.ram_waddr), 1023);
            if (i == 1025) chk("deep_ptr_wrap", 32'(bus.ram_waddr), 0);
            tick();
            if (i == 1023) chk("deep_still_fill", 32'(bus.state), 1);
            if (i == 1024) chk("deep_run", 32'(bus.state), 2);
            chk("deep_ov", 32'(bus.out_valid), (i >= 1025) ? 1 : 0);
            if (i >= 1025) chk("deep_data", 32'(bus.out_data), i - 1024);
        end
        bus.in_valid = 1'b0;
        bus.enable   = 1'b0;
        tick();
        chk("deep_idle", 32'(bus.state), 0);
    endtask

    initial begin
        int n;
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.clear     = 1'b0;
        bus.cfg_len   = 11'd4;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        #2;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_re", 32'(bus.ram_re), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("idle_no_enable", 32'(bus.state), 0);

        // len 4, continuous stream; cfg_len change mid-RUN must not matter
        bus.enable = 1'b1;
        tick();
        chk("fill_entry", 32'(bus.state), 1);
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) bus.cfg_len = 11'd2;
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i);
            #1;
            chk("cont_we", 32'(bus.ram_we), 1);
            chk("cont_re", 32'(bus.ram_re), 1);
            chk("cont_addr", 32'(bus.ram_waddr), (i - 1) % 4);
            chk("cont_wdata", 32'(bus.ram_wdata), i);
            tick();
            chk("cont_state", 32'(bus.state), (i < 4) ? 1 : 2);
            chk("cont_ov", 32'(bus.out_valid), (i >= 5) ? 1 : 0);
            if (i >= 5) chk("cont_data", 32'(bus.out_data), i - 4);
        end
        bus.cfg_len = 11'd4;

        // clear in RUN with a sample offered
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd99;
        #1;
        chk("clr_no_we", 32'(bus.ram_we), 0);
        tick();
        chk("clr_idle", 32'(bus.state), 0);
        chk("clr_ov", 32'(bus.out_valid), 0);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("refill_entry", 32'(bus.state), 1);

        // alternating in_valid after refill
        n = 0;
        for (int j = 0; j < 24; j++) begin
            if (j % 2 == 0) begin
                n++;
                bus.in_valid = 1'b1;
                bus.in_data  = 16'(n);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            chk("gap_we", 32'(bus.ram_we), (j % 2 == 0) ? 1 : 0);
            if (j % 2 == 1) chk("gap_ptr_hold", 32'(bus.ram_waddr), n % 4);
            tick();
            chk("gap_ov", 32'(bus.out_valid), ((j % 2 == 0) && n >= 5) ? 1 : 0);
            if ((j % 2 == 0) && n >= 5) chk("gap_data", 32'(bus.out_data), n - 4);
            chk("gap_state", 32'(bus.state), (n < 4) ? 1 : 2);
        end

        // enable drop with a sample offered
        bus.enable   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd77;
        #1;
        chk("dis_no_we", 32'(bus.ram_we), 0);
        tick();
        chk("dis_idle", 32'(bus.state), 0);
        chk("dis_ov", 32'(bus.out_valid), 0);
        bus.in_valid = 1'b0;

        // len 1: each output is the previous sample
        bus.cfg_len = 11'd1;
        bus.enable  = 1'b1;
        tick();
        chk("len1_fill", 32'(bus.state), 1);
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(100 + i);
            #1;
            chk("len1_ptr", 32'(bus.ram_waddr), 0);
            tick();
            chk("len1_state", 32'(bus.state), 2);
            chk("len1_ov", 32'(bus.out_valid), (i >= 2) ? 1 : 0);
            if (i >= 2) chk("len1_data", 32'(bus.out_data), 100 + i - 1);
        end
        bus.in_valid = 1'b0;
        bus.enable   = 1'b0;
        tick();

        run_deep(0);
        run_deep(1024);
        run_deep(2000);

        // async reset mid-RUN
        bus.cfg_len = 11'd4;
        bus.enable  = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(200 + i);
            tick();
        end
        chk("pre_rst_ov", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_ov", 32'(bus.out_valid), 0);
        chk("arst_we", 32'(bus.ram_we), 0);
        #2;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("post_rst_fill", 32'(bus.state), 1);
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(300 + i);
            tick();
            chk("post_rst_ov", 32'(bus.out_valid), (i == 5) ? 1 : 0);
        end
        chk("post_rst_data", 32'(bus.out_data), 301);
        bus.in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_ram_ctrl.md
SHIFT_RAM_CTRL -- requirements
Module: shift_ram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of delayed samples and RAM data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10: RAM address width; DEPTH = 2^ADDR_WIDTH (1024).
REQ-003 The block SHALL have clk, input, 1: single clock for all logic and both RAM ports (RAM in one-clock mode).
REQ-004 The block SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have enable, input, 1: high = delay line active; low = return to IDLE.
REQ-006 The block SHALL have clear, input, 1: synchronous flush of the delay line.
REQ-007 The block SHALL have cfg_len, input, ADDR_WIDTH+1: delay in accepted samples, legal 1..DEPTH.
REQ-008 The block SHALL have in_valid, input, 1: in_data is a new sample this cycle.
REQ-009 The block SHALL have in_data, input, DATA_WIDTH: sample to delay.
REQ-010 The block SHALL have out_valid, output, 1: out_data holds a delayed sample.
REQ-011 The block SHALL have out_data, output, DATA_WIDTH: delayed sample, equal to ram_rdata.
REQ-012 The block SHALL have state, output, 2: 00 IDLE, 01 FILL, 10 RUN.
REQ-013 The block SHALL have ram_we, output, 1: RAM write enable, active high.
REQ-014 The block SHALL have ram_waddr, output, ADDR_WIDTH: RAM write address.
REQ-015 The block SHALL have ram_wdata, output, DATA_WIDTH: RAM write data.
REQ-016 The block SHALL have ram_re, output, 1: RAM read enable, active high.
REQ-017 The block SHALL have ram_raddr, output, ADDR_WIDTH: RAM read address.
REQ-018 The block SHALL have ram_rdata, input, DATA_WIDTH: RAM read data; attached RAM is READ_FIRST with 1-cycle read latency (no output register).

Function
REQ-019 The FSM SHALL have three states: IDLE, FILL and RUN.
REQ-020 In IDLE with enable=1 and clear=0, the block SHALL latch len_q from cfg_len and go to FILL next cycle.
REQ-021 A cfg_len of 0 or greater than DEPTH SHALL latch as DEPTH.
REQ-022 cfg_len SHALL be sampled only on the IDLE->FILL transition and ignored at all other times.
REQ-023 In FILL or RUN, each in_valid=1 cycle SHALL assert ram_we=ram_re=1, ram_waddr=ram_raddr=ptr and ram_wdata=in_data in that same cycle (combinational from inputs and ptr).
REQ-024 ptr SHALL advance by 1 per accepted sample and wrap to 0 after value len_q-1.
REQ-025 When in_valid=0 or the state is IDLE, the block SHALL hold ram_we=ram_re=0 and hold ptr.
REQ-026 fill_cnt SHALL count accepted samples in FILL; on the accepted sample with fill_cnt==len_q-1 the block SHALL go to RUN.
REQ-027 out_valid SHALL be a register set to 1 the cycle after an accepted sample taken while in RUN, and 0 otherwise.
REQ-028 The delay SHALL be exactly len_q accepted samples: the sample accepted at RUN index k outputs input sample k, one cycle after acceptance.
REQ-029 Gaps in in_valid SHALL not corrupt the delay line, because ptr and fill_cnt hold during gaps.
REQ-030 Precedence: clear=1 SHALL force IDLE next cycle with ptr=0, fill_cnt=0, out_valid=0 and no RAM access that cycle; clear overrides enable.
REQ-031 Precedence: enable=0 (with clear=0) SHALL force IDLE with ptr=0, fill_cnt=0, and out_valid=0 the next cycle; a sample offered in that same cycle SHALL be dropped.
REQ-032 len_q=1 SHALL keep ptr at 0, go from FILL to RUN after the first sample, and make each output equal the previous accepted sample.
REQ-033 RAM contents SHALL never be cleared; stale data is hidden because out_valid stays 0 until the refill completes.

Reset
REQ-034 While rst_n=0, asynchronously: state=IDLE, ptr=0, fill_cnt=0, len_q=DEPTH, out_valid=0; ram_we and ram_re SHALL be 0.
REQ-035 After rst_n deasserts, the block SHALL take no action before the first rising clk edge; reset mid-FILL or mid-RUN SHALL discard all progress.

Verification
REQ-036 Scenario: cfg_len=4, enable=1, continuous in_valid with in_data=1,2,3,... -> state FILL for 4 samples, first out_valid aligned with out_data=1 the cycle after sample 5, then 2,3,... every cycle.
REQ-037 Scenario: cfg_len=4, in_valid toggled 1/0 -> out_valid only follows accepted samples; the sequence stays 1,2,3,... with no skips or repeats.
REQ-038 Scenario: cfg_len=1024 versus cfg_len=0 -> identical behaviour; first valid output after 1025 accepted samples; ptr wraps 1023->0.
REQ-039 Scenario: cfg_len=1 -> after the first sample, out_data equals the previous sample each cycle; ptr constant at 0.
REQ-040 Scenario: clear pulse in RUN with in_valid=1 -> no ram_we that cycle, IDLE next cycle, out_valid=0; after re-enable, the refill needs len_q samples before out_valid.
REQ-041 Scenario: rst_n low mid-RUN asynchronously -> out_valid=0 and state=00 immediately; cfg_len change during RUN has no effect until the next IDLE->FILL transition.
